instr_encoder: RTL and testbench
================================

# instr_encoder

- Program-load front end that feeds the instruction memory read by the main control decoder.
- Accepts one instruction request per handshake, using fields and a kind code, and encodes it into a 32-bit MIPS word.
- Buffers encoded words in a small FIFO.
- Writes words sequentially into instruction memory from BASE_ADDR upward, then reports completion.

## Interface
- DEPTH, 4: FIFO depth in words; power of two, at least 2
- ADDR_W, 8: instruction-memory word-address width
- BASE_ADDR, 0: first word address written after start
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a load session; honored only in IDLE
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid and in_ready are both high
- in_kind  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=JUMP, 5=ADDI, 6/7=illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_funct  in  6  R-type function field
- in_imm  in  16  I-type immediate
- in_target  in  26  jump target
- in_last  in  1  marks the final request of the session
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse on session completion
- count  out  ADDR_W+1  words written this session
- err  out  1  sticky error; cleared by start or reset

## Operation
- Encoding rules:
  - R-type: {6'd0, rs, rt, rd, 5'd0, funct}
  - LW, SW, BEQ, ADDI: {op, rs, rt, imm}, with op = 35 / 43 / 4 / 8 respectively
  - JUMP: {6'd2, target}
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE → LOAD on start. In the same edge, clear count and err, and load the write pointer with BASE_ADDR.
  - LOAD: in_ready = !fifo_full. On the edge where a request with in_last is accepted, go to DRAIN.
  - DRAIN: in_ready = 0. Go to DONE once the FIFO is empty and no write is pending.
  - DONE: done = 1 for exactly one cycle, then return to IDLE.
  - in_ready = 0 in IDLE, DRAIN and DONE.
- Write side, active in LOAD and DRAIN:
  - Each cycle the FIFO is non-empty, pop one word and drive imem_we = 1 with imem_addr = pointer and imem_wdata = word.
  - Increment the pointer and count on each write.
- Address overflow:
  - Once 2^ADDR_W words have been written, further popped words are discarded with no imem_we, and err is set.
  - count saturates at 2^ADDR_W; the pointer does not wrap.
- Simultaneous push and pop on a full FIFO is legal. in_ready depends only on registered fullness, not on the same-cycle pop.
- start asserted outside IDLE is ignored.
- Reset mid-session:
  - FIFO flushed, state set to IDLE, all outputs set to reset values.
  - No write occurs in the reset cycle.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, count=0, err=0.
- Latency: a request accepted at edge N produces imem_we at cycle N+1 at the earliest (encode in front of a registered FIFO).
- Throughput: one word per cycle sustained.
- imem_addr and imem_wdata are held at their last values when imem_we=0.
- done follows the final write by exactly 2 cycles: one cycle to leave DRAIN, then DONE.

## Configuration
- ENC_CHECK_EN defined:
  - An accepted request with kind 6 or 7, or an R-type request with nonzero in_funct[5:4] outside {2'b00, 2'b10}, is consumed but not stored.
  - err is set.
  - An in_last on such a request still ends the session.
- ENC_CHECK_EN undefined:
  - Illegal kinds encode as 32'h0000_0000 (NOP) and are written normally.
  - err reflects address overflow only.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2, OP_ADDI=8;
  - the in_kind encoding constants;
  - the instruction field widths.
- One sub-module, instr_fifo: parameterised by DEPTH, 32-bit data, push/pop/full/empty, synchronous reset flush.
- The encoder and FSM live in instr_encoder.

## Test plan
- R-type: start, then request rs=1, rt=2, rd=3, funct=0x20, last → imem_we one cycle after accept, addr 0, wdata 0x00221820; done 2 cycles after the write; count=1.
- Five back-to-back requests:
  - LW rs=29, rt=8, imm=4 → 0x8FA80004
  - SW → opcode 43
  - BEQ rs=1, rt=2, imm=0xFFFF → 0x1022FFFF
  - JUMP target=0x10 → 0x08000010
  - ADDI rs=0, rt=5, imm=7 (last) → 0x20050007
  - Required: addresses 0..4 consecutive, count=5, err=0.
- Backpressure: DEPTH=4, hold in_valid for 8 requests → in_ready never lets the FIFO exceed 4 entries; all 8 words are written in order with no loss.
- Overflow: ADDR_W=2, 6 requests → exactly 4 writes at addresses 0..3, count=4, err=1, done still pulses.
- Illegal kind=7 mid-stream:
  - With ENC_CHECK_EN: word skipped, err=1, following word written at the next address.
  - Without ENC_CHECK_EN: 0x00000000 written, err=0.
- reset asserted during DRAIN with 3 words queued → no further imem_we, all outputs at reset values next cycle; a new start works normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, field widths and encoder state type.
package mips_pkg;

    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;
    localparam int KIND_W  = 3;
    localparam int WORD_W  = 32;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPC_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPC_W-1:0] OP_SW    = 6'd43;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPC_W-1:0] OP_J     = 6'd2;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd8;

    localparam logic [KIND_W-1:0] K_R    = 3'd0;
    localparam logic [KIND_W-1:0] K_LW   = 3'd1;
    localparam logic [KIND_W-1:0] K_SW   = 3'd2;
    localparam logic [KIND_W-1:0] K_BEQ  = 3'd3;
    localparam logic [KIND_W-1:0] K_JUMP = 3'd4;
    localparam logic [KIND_W-1:0] K_ADDI = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [WORD_W-1:0] enc_itype(
        input logic [OPC_W-1:0] op,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [IMM_W-1:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Registered word FIFO with synchronous flush; push and pop may
// coincide on a full FIFO.
module instr_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q;
    logic [AW:0]  rp_q;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wp_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (do_pop) begin
                rp_q <= rp_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-load front end: encodes requests to MIPS words and writes imem.
// Define ENC_CHECK_EN to drop and flag illegal requests.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KIND_W-1:0] in_kind,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [FUNCT_W-1:0] in_funct,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [TGT_W-1:0]  in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [ADDR_W:0]     count_q;
    logic                err_q;
    logic                stop_q;

    logic [WORD_W-1:0]   enc_word;
    logic                enc_ok;
    logic                rdy;
    logic                in_fire;
    logic                f_push;
    logic                f_full;
    logic                f_empty;
    logic [WORD_W-1:0]   f_dout;
    logic                wr_act;
    logic                sess_go;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        unique case (1'b1)
            (in_kind == K_R): begin
                enc_word = {OP_RTYPE, in_rs, in_rt, in_rd,
                            {SHAMT_W{1'b0}}, in_funct};
`ifdef ENC_CHECK_EN
                enc_ok = !in_funct[4];
`endif
            end
            (in_kind == K_LW):
                enc_word = enc_itype(OP_LW, in_rs, in_rt, in_imm);
            (in_kind == K_SW):
                enc_word = enc_itype(OP_SW, in_rs, in_rt, in_imm);
            (in_kind == K_BEQ):
                enc_word = enc_itype(OP_BEQ, in_rs, in_rt, in_imm);
            (in_kind == K_JUMP):
                enc_word = {OP_J, in_target};
            (in_kind == K_ADDI):
                enc_word = enc_itype(OP_ADDI, in_rs, in_rt, in_imm);
            default: begin
                enc_word = '0;
`ifdef ENC_CHECK_EN
                enc_ok = 1'b0;
`endif
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                rdy = !f_full;
                if (in_valid && rdy && in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (f_empty) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready = rdy && !reset;
    assign in_fire  = in_valid && in_ready;
    assign f_push   = in_fire && enc_ok;
    assign sess_go  = (state_q == S_IDLE) && start;

    // Writes are combinational off the registered FIFO head; reset blocks them.
    assign wr_act = ((state_q == S_LOAD) || (state_q == S_DRAIN)) &&
                    !f_empty && !reset;

    assign imem_we    = wr_act && !stop_q;
    assign imem_addr  = imem_we ? ptr_q  : addr_q;
    assign imem_wdata = imem_we ? f_dout : wdata_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign count      = count_q;
    assign err        = err_q;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (f_push),
        .din   (enc_word),
        .pop   (wr_act),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE_ADDR;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sess_go) begin
                ptr_q   <= BASE_ADDR;
                count_q <= '0;
                err_q   <= 1'b0;
                stop_q  <= 1'b0;
            end else begin
                if (imem_we) begin
                    addr_q  <= ptr_q;
                    wdata_q <= f_dout;
                    count_q <= count_q + 1'b1;
                    // The top address is terminal: stop rather than wrap.
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        stop_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                if (wr_act && stop_q) begin
                    err_q <= 1'b1;
                end
`ifdef ENC_CHECK_EN
                if (in_fire && !enc_ok) begin
                    err_q <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: default DUT plus ADDR_W=2 DUT.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        valid_a, valid_b;
    logic        rdy_a, rdy_b;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;

    logic        we_a, we_b;
    logic [7:0]  addr_a;
    logic [1:0]  addr_b;
    logic [31:0] wd_a, wd_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [8:0]  cnt_a;
    logic [2:0]  cnt_b;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_we_a = 0;
    int   acc_cyc = 0;
    int   acc_a = 0;
    int   wr_a = 0;
    int   ea = 0;
    int   eb = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .in_valid(valid_a), .in_ready(rdy_a), .in_kind(kind),
        .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_funct(funct),
        .in_imm(imm), .in_target(target), .in_last(last),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
        .busy(busy_a), .done(done_a), .count(cnt_a), .err(err_a)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .in_valid(valid_b), .in_ready(rdy_b), .in_kind(kind),
        .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_funct(funct),
        .in_imm(imm), .in_target(target), .in_last(last),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
        .busy(busy_b), .done(done_b), .count(cnt_b), .err(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (we_a) begin
            wr_a++;
            last_we_a = cyc;
            if (qa.size() == 0) begin
                chk("a_unexpected_write", {24'd0, addr_a}, 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                chk("a_addr", {24'd0, addr_a}, {24'd0, e.addr});
                chk("a_data", wd_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (we_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_write", {30'd0, addr_b}, 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                chk("b_addr", {30'd0, addr_b}, {24'd0, e.addr});
                chk("b_data", wd_b, e.data);
            end
        end
    end

    task automatic send(input bit sel, input logic [2:0] k,
                        input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [5:0] f,
                        input logic [15:0] im, input logic [25:0] tg,
                        input bit l, input bit push, input logic [31:0] w);
        int  n;
        bit  acc;
        exp_t e;
        kind = k; rs = s; rt = t; rd = d; funct = f;
        imm = im; target = tg; last = l;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = sel ? rdy_b : rdy_a;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        if (acc) begin
            if (!sel) begin
                acc_a++;
                chk("a_occupancy_le_depth", {31'd0, (acc_a - wr_a) <= 4},
                    32'd1);
            end
            if (push) begin
                e.data = w;
                if (sel) begin
                    e.addr = eb[7:0];
                    qb.push_back(e);
                    eb++;
                end else begin
                    e.addr = ea[7:0];
                    qa.push_back(e);
                    ea++;
                end
            end
        end
    endtask

    task automatic start_sess(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (sel) eb = 0; else ea = 0;
        acc_a = 0;
        wr_a = 0;
    endtask

    task automatic wait_done(input bit sel, input int exp_cnt,
                             input bit exp_err, input bit gap);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (sel ? done_b : done_a) begin
                if (sel) begin
                    chk("b_count", {29'd0, cnt_b}, exp_cnt);
                    chk("b_err", {31'd0, err_b}, {31'd0, exp_err});
                end else begin
                    chk("a_count", {23'd0, cnt_a}, exp_cnt);
                    chk("a_err", {31'd0, err_a}, {31'd0, exp_err});
                    if (gap) chk("a_done_gap", cyc - last_we_a, 2);
                end
                break;
            end
            n++;
            if (n > 200) begin
                chk("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a();
        chk("rst_in_ready", {31'd0, rdy_a}, 0);
        chk("rst_imem_we", {31'd0, we_a}, 0);
        chk("rst_imem_addr", {24'd0, addr_a}, 0);
        chk("rst_imem_wdata", wd_a, 0);
        chk("rst_busy", {31'd0, busy_a}, 0);
        chk("rst_done", {31'd0, done_a}, 0);
        chk("rst_count", {23'd0, cnt_a}, 0);
        chk("rst_err", {31'd0, err_a}, 0);
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; funct = '0;
        imm = '0; target = '0; last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_a();
        @(posedge clk);
        #1;

        // single R-type: latency and done spacing
        start_sess(0);
        chk("a_busy_load", {31'd0, busy_a}, 1);
        send(0, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1, 1,
             32'h0022_1820);
        wait_done(0, 1, 0, 1);
        chk("a_latency", last_we_a - acc_cyc, 1);

        // five back-to-back kinds
        start_sess(0);
        send(0, 3'd1, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 0, 1,
             32'h8FA8_0004);
        send(0, 3'd2, 5'd29, 5'd9, 5'd0, 6'h0, 16'h0008, 26'h0, 0, 1,
             32'hAFA9_0008);
        send(0, 3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 0, 1,
             32'h1022_FFFF);
        send(0, 3'd4, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 0, 1,
             32'h0800_0010);
        send(0, 3'd5, 5'd0, 5'd5, 5'd0, 6'h0, 16'h0007, 26'h0, 1, 1,
             32'h2005_0007);
        wait_done(0, 5, 0, 1);

        // eight requests with valid held high
        start_sess(0);
        for (int i = 0; i < 8; i++) begin
            send(0, 3'd5, 5'd0, 5'd1, 5'd0, 6'h0, 16'(i), 26'h0,
                 i == 7, 1, 32'h2001_0000 + i);
        end
        wait_done(0, 8, 0, 1);

        // overflow on 2-bit address DUT
        start_sess(1);
        for (int i = 0; i < 6; i++) begin
            send(1, 3'd5, 5'd0, 5'd2, 5'd0, 6'h0, 16'(i), 26'h0,
                 i == 5, i < 4, 32'h2002_0000 + i);
        end
        wait_done(1, 4, 1, 0);

        // illegal kind mid-stream
        start_sess(0);
        send(0, 3'd5, 5'd0, 5'd3, 5'd0, 6'h0, 16'h1, 26'h0, 0, 1,
             32'h2003_0001);
`ifdef ENC_CHECK_EN
        send(0, 3'd7, 5'd1, 5'd1, 5'd1, 6'h0, 16'h1, 26'h0, 0, 0, 32'h0);
`else
        send(0, 3'd7, 5'd1, 5'd1, 5'd1, 6'h0, 16'h1, 26'h0, 0, 1, 32'h0);
`endif
        send(0, 3'd5, 5'd0, 5'd3, 5'd0, 6'h0, 16'h2, 26'h0, 1, 1,
             32'h2003_0002);
`ifdef ENC_CHECK_EN
        wait_done(0, 2, 1, 1);
`else
        wait_done(0, 3, 0, 1);
`endif

        // reset while the last word is still queued in DRAIN
        start_sess(0);
        send(0, 3'd5, 5'd0, 5'd4, 5'd0, 6'h0, 16'h1, 26'h0, 0, 1,
             32'h2004_0001);
        send(0, 3'd5, 5'd0, 5'd4, 5'd0, 6'h0, 16'h2, 26'h0, 0, 1,
             32'h2004_0002);
        send(0, 3'd5, 5'd0, 5'd4, 5'd0, 6'h0, 16'h3, 26'h0, 1, 0,
             32'h0);
        chk("a_busy_drain", {31'd0, busy_a}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_a();
        chk("a_queue_after_reset", qa.size(), 0);
        @(posedge clk);
        #1;

        start_sess(0);
        send(0, 3'd0, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0, 26'h0, 1, 1,
             32'h0085_3022);
        wait_done(0, 1, 0, 1);

        repeat (3) @(posedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
